instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 127 ++++++++++++
 tb/tb_instr_mem_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: receives a length-prefixed, XOR-checksummed image stream and
// writes its payload byte by byte into the instruction memory. The processor core
// is held in reset until a complete frame with a matching checksum has been loaded.
module instr_mem_loader #(
    parameter  int DEPTH = 256,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             cpu_rst_n
);

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StCsum,
        StDone,
        StErr
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    len_lo_q;
    logic [15:0]   len_q;
    logic [AW-1:0] cnt_q;
    logic [7:0]    csum_q;

    logic          accept;
    logic [15:0]   len_full;
    logic          last_byte;
    logic          is_busy_d;

    assign accept    = in_valid && in_ready;
    // Length as it will be once the high byte currently on in_data is taken.
    assign len_full  = {in_data, len_lo_q};
    // Payload byte N-1 is the one at cnt_q; compared wide so N = DEPTH never wraps.
    assign last_byte = (17'(cnt_q) == (17'(len_q) - 17'd1));
    assign is_busy_d = (state_d == StLenLo) || (state_d == StLenHi) ||
                       (state_d == StData)  || (state_d == StCsum);

    // Next-state decode of the frame parser.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) state_d = StLenLo;
            end
            StLenLo: begin
                if (accept) state_d = StLenHi;
            end
            StLenHi: begin
                if (accept) begin
                    if (17'(len_full) > 17'(DEPTH)) state_d = StErr;
                    else if (len_full == 16'd0)     state_d = StCsum;
                    else                            state_d = StData;
                end
            end
            StData: begin
                if (accept && last_byte) state_d = StCsum;
            end
            StCsum: begin
                if (accept) state_d = (in_data == csum_q) ? StDone : StErr;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, datapath and registered outputs; flags follow the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            len_lo_q  <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            csum_q    <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= is_busy_d;
            busy      <= is_busy_d;
            done      <= (state_d == StDone);
            error     <= (state_d == StErr);
            cpu_rst_n <= (state_d == StDone);
            mem_we    <= 1'b0;

            if ((state_q == StIdle || state_q == StDone || state_q == StErr) && start) begin
                cnt_q  <= '0;
                csum_q <= '0;
            end

            if (accept) begin
                case (state_q)
                    StLenLo: len_lo_q <= in_data;
                    StLenHi: len_q    <= len_full;
                    StData: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= cnt_q;
                        mem_wdata <= in_data;
                        csum_q    <= csum_q ^ in_data;
                        if (!last_byte) cnt_q <= cnt_q + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: expected memory writes are queued as
// payload is driven and popped as the DUT strobes mem_we.
module tb_instr_mem_loader;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic          done;
    logic          error;
    logic          cpu_rst_n;

    int n_cmp = 0;
    int n_err = 0;
    int wr_count = 0;
    logic [15:0] sb_q[$];
    logic [7:0]  payload[0:299];

    instr_mem_loader #(
        .DEPTH(DEPTH),
        .WIDTH(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_rst_n(cpu_rst_n)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued payload byte.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            wr_count++;
            if (sb_q.size() == 0) begin
                check_eq("unexpected_write", {mem_addr, mem_wdata}, 32'hdead);
            end else begin
                check_eq("write", {mem_addr, mem_wdata}, sb_q.pop_front());
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        bit sent = 1'b0;
        int gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 100 && !sent; i++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                sent = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!sent) begin
            in_valid = 1'b0;
            check_eq("send_timeout", 32'd0, 32'd1);
        end
    endtask

    // Drives a full frame; payload bytes are only sent when N fits in memory.
    task automatic run_frame(input int n, input logic [7:0] cs, input int maxgap);
        logic [15:0] len;
        len = 16'(n);
        pulse_start();
        send_byte(len[7:0], maxgap);
        send_byte(len[15:8], maxgap);
        if (n <= DEPTH) begin
            for (int k = 0; k < n; k++) begin
                sb_q.push_back({8'(k), payload[k]});
                send_byte(payload[k], maxgap);
            end
            send_byte(cs, maxgap);
        end
    endtask

    task automatic wait_end(input string tag);
        for (int i = 0; i < 50 && !(done || error); i++) @(negedge clk);
        check_eq({tag, "_end_timeout"}, 32'(done | error), 32'd1);
    endtask

    // Compares {done, error, cpu_rst_n, busy, in_ready}.
    task automatic check_flags(input string tag, input logic [4:0] exp);
        check_eq(tag, {done, error, cpu_rst_n, busy, in_ready}, {27'd0, exp});
    endtask

    initial begin
        logic [7:0] x;
        int w0;

        #12;
        check_eq("reset_outputs",
                 {in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_rst_n},
                 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_flags("idle_after_reset", 5'b00000);

        // 04 00 13 00 00 00 13 -> done
        payload[0] = 8'h13; payload[1] = 8'h00; payload[2] = 8'h00; payload[3] = 8'h00;
        run_frame(4, 8'h13, 0);
        wait_end("good4");
        check_flags("good4_flags", 5'b10100);
        check_eq("good4_drained", 32'(sb_q.size()), 32'd0);

        // Same frame with bad checksum -> error, core held
        run_frame(4, 8'h12, 1);
        wait_end("bad4");
        check_flags("bad4_flags", 5'b01000);
        check_eq("bad4_drained", 32'(sb_q.size()), 32'd0);

        // N = 257 -> error right after LEN_HI, no writes
        w0 = wr_count;
        run_frame(257, 8'h00, 0);
        check_flags("oversize_flags", 5'b01000);
        repeat (3) @(negedge clk);
        check_eq("oversize_writes", 32'(wr_count - w0), 32'd0);

        // N = 0, checksum 00 -> done; checksum 5A -> error
        w0 = wr_count;
        run_frame(0, 8'h00, 0);
        wait_end("empty_ok");
        check_flags("empty_ok_flags", 5'b10100);
        run_frame(0, 8'h5a, 0);
        wait_end("empty_bad");
        check_flags("empty_bad_flags", 5'b01000);
        check_eq("empty_writes", 32'(wr_count - w0), 32'd0);

        // N = DEPTH with random gaps
        x = 8'h00;
        for (int k = 0; k < DEPTH; k++) begin
            payload[k] = 8'($urandom_range(255, 0));
            x = x ^ payload[k];
        end
        w0 = wr_count;
        run_frame(DEPTH, x, 3);
        wait_end("full");
        check_flags("full_flags", 5'b10100);
        check_eq("full_writes", 32'(wr_count - w0), 32'(DEPTH));
        check_eq("full_drained", 32'(sb_q.size()), 32'd0);

        // Reset mid-DATA after payload bytes 0 and 1
        payload[0] = 8'hb7; payload[1] = 8'h42; payload[2] = 8'h99; payload[3] = 8'h01;
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        sb_q.push_back({8'd0, payload[0]});
        send_byte(payload[0], 0);
        sb_q.push_back({8'd1, payload[1]});
        send_byte(payload[1], 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midreset_outputs",
                 {in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_rst_n},
                 32'd0);
        check_eq("midreset_drained", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_flags("midreset_idle", 5'b00000);
        x = payload[0] ^ payload[1] ^ payload[2] ^ payload[3];
        run_frame(4, x, 2);
        wait_end("reload");
        check_flags("reload_flags", 5'b10100);

        repeat (3) @(negedge clk);
        check_eq("final_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
